// File: rtl/des_decrypt_core_if.sv
// Handshake bundle for the DES decryption core: block/key in, plaintext out.
interface des_decrypt_core_if;
  localparam int unsigned BLK_W = 64;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] ciphertext;
  logic [BLK_W-1:0] key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] plaintext;
  logic             busy;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
endinterface

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: 16 Feistel rounds with subkeys K16..K1,
// ROUNDS_PER_CYCLE rounds evaluated per clock.
module des_decrypt_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst,
  des_decrypt_core_if.slave bus
);
  localparam int unsigned BLK_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned CD_W   = 28;
  localparam int unsigned SUB_W  = 48;
  localparam int unsigned RND_W  = 4;

  localparam logic [RND_W-1:0] RND_STEP = RND_W'(ROUNDS_PER_CYCLE);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(16 - ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Tables use FIPS 1-based numbering; FIPS bit n lives at vector bit (width - n).
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // Right-rotate amount applied before decryption round i (round 1 uses C0||D0 as is).
  localparam int unsigned SHIFT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // S1..S8, each as four rows of 16 entries.
  localparam int unsigned SBOX_T [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [BLK_W-1:0] ip_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] fp_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
    return y;
  endfunction

  function automatic logic [2*CD_W-1:0] pc1_perm(input logic [BLK_W-1:0] x);
    logic [2*CD_W-1:0] y;
    y = '0;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
    return y;
  endfunction

  function automatic logic [SUB_W-1:0] pc2_perm(input logic [2*CD_W-1:0] x);
    logic [SUB_W-1:0] y;
    y = '0;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] feistel(input logic [HALF_W-1:0] r,
                                                input logic [SUB_W-1:0]  k);
    logic [SUB_W-1:0]  ex;
    logic [HALF_W-1:0] s;
    logic [HALF_W-1:0] y;
    logic [5:0]        six;
    ex = '0;
    s  = '0;
    y  = '0;
    for (int i = 0; i < 48; i++) ex[6'(47 - i)] = r[5'(32 - E_T[i])];
    ex = ex ^ k;
    // Row is the outer bit pair {b1,b6}, column the inner four bits.
    for (int b = 0; b < 8; b++) begin
      six = ex[6'(47 - 6 * b) -: 6];
      s[5'(31 - 4 * b) -: 4] = 4'(SBOX_T[{3'(b), six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {x[0], x[CD_W-1:1]};
      2'd2:    rotr = {x[1:0], x[CD_W-1:2]};
      default: rotr = x;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t            state_q, state_d;
  logic [HALF_W-1:0] l_q, l_d, r_q, r_d, l_rnd, r_rnd, f_tmp;
  logic [CD_W-1:0]   c_q, c_d, d_q, d_d, c_rnd, d_rnd;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic              out_valid_q, out_valid_d;
  logic [BLK_W-1:0]  plaintext_q, plaintext_d;

  // Unrolled block of ROUNDS_PER_CYCLE decryption rounds starting at round rnd_q+1.
  always_comb begin
    l_rnd = l_q;
    r_rnd = r_q;
    c_rnd = c_q;
    d_rnd = d_q;
    f_tmp = '0;
    for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      c_rnd = rotr(c_rnd, 2'(SHIFT_T[rnd_q + RND_W'(j)]));
      d_rnd = rotr(d_rnd, 2'(SHIFT_T[rnd_q + RND_W'(j)]));
      f_tmp = l_rnd ^ feistel(r_rnd, pc2_perm({c_rnd, d_rnd}));
      l_rnd = r_rnd;
      r_rnd = f_tmp;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    plaintext_d = plaintext_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          {l_d, r_d} = ip_perm(bus.ciphertext);
          {c_d, d_d} = pc1_perm(bus.key);
          rnd_d      = '0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        l_d   = l_rnd;
        r_d   = r_rnd;
        c_d   = c_rnd;
        d_d   = d_rnd;
        rnd_d = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) begin
          plaintext_d = fp_perm({r_rnd, l_rnd});
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      plaintext_q <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      plaintext_q <= plaintext_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.plaintext = plaintext_q;
endmodule
